// File: rtl/gh_pkg.sv
// rtl/gh_pkg.sv - shared constants, adder state type and BCD increment helper for the hit judge.
package gh_pkg;
  localparam int LANES = 4;
  localparam int DIGIT_W = 4;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

  typedef enum logic {IDLE, ADD} add_state_t;

  // Ripple +1 through four BCD digits; a 9 wraps to 0 and carries onward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic carry;
    r = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[d*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          r[d*DIGIT_W +: DIGIT_W] = v[d*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - four-digit BCD up-counter that sticks at 9999.
module bcd_counter4
  import gh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && count != SCORE_MAX_BCD) begin
      count <= bcd_inc(count);
    end
  end
endmodule

// File: rtl/hit_judge_scorer.sv
// rtl/hit_judge_scorer.sv - judges key presses against bottom-row notes and feeds a BCD score.
module hit_judge_scorer
  import gh_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STREAK_STEP = 8,
  parameter int MAX_MULT    = 4,
  parameter int STREAK_MAX  = 63
) (
  input  logic             CLOCK_50,
  input  logic             RESET_GAME,
  input  logic             note_tick,
  input  logic [LANES-1:0] lane_note,
  input  logic [LANES-1:0] KEY_N,
  output logic [15:0]      score_bcd,
  output logic [5:0]       streak,
  output logic [2:0]       multiplier,
  output logic [LANES-1:0] hit_flags,
  output logic [LANES-1:0] miss_flags,
  output logic [LANES-1:0] false_flags,
  output logic             busy
);
  logic [SYNC_STAGES-1:0][LANES-1:0] sync_q;
  logic [LANES-1:0] pressed, press_prev, key_edge, press_latch, window;
  logic [LANES-1:0] hit_now, miss_now, false_now;
  logic [5:0]       streak_next;
  logic [2:0]       hit_cnt;
  logic [5:0]       points;
  logic [6:0]       pending_sum;
  logic [4:0]       pending, pending_next;
  logic             inc;
  add_state_t       state, state_next;

  function automatic logic [2:0] mult_for(input logic [5:0] s);
    int m;
    m = 1 + int'(s) / STREAK_STEP;
    if (m > MAX_MULT) m = MAX_MULT;
    return 3'(m);
  endfunction

  assign pressed   = sync_q[SYNC_STAGES-1];
  assign key_edge  = pressed & ~press_prev;
  // An edge landing on the tick cycle still belongs to the window being closed.
  assign window    = press_latch | key_edge;
  assign hit_now   = lane_note & window;
  assign miss_now  = lane_note & ~window;
  assign false_now = window & ~lane_note;

  always_ff @(posedge CLOCK_50 or posedge RESET_GAME) begin
    if (RESET_GAME) begin
      sync_q      <= '0;
      press_prev  <= '0;
      press_latch <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ~KEY_N};
      press_prev  <= pressed;
      press_latch <= note_tick ? '0 : (press_latch | key_edge);
    end
  end

  always_comb begin
    streak_next = streak;
    if ((miss_now | false_now) != '0) begin
      streak_next = '0;
    end else if (hit_now != '0 && streak != 6'(STREAK_MAX)) begin
      streak_next = streak + 6'd1;
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + {2'b0, hit_now[i]};
  end

  // Points use the multiplier in force before this tick's streak update.
  assign points      = {3'b0, hit_cnt} * {3'b0, multiplier};
  assign inc         = (state == ADD) && (pending != '0);
  assign pending_sum = {2'b0, pending} - {6'b0, inc} + (note_tick ? {1'b0, points} : 7'd0);
  assign pending_next = (pending_sum > 7'd31) ? 5'd31 : pending_sum[4:0];

  always_ff @(posedge CLOCK_50 or posedge RESET_GAME) begin
    if (RESET_GAME) begin
      streak      <= '0;
      multiplier  <= 3'd1;
      hit_flags   <= '0;
      miss_flags  <= '0;
      false_flags <= '0;
      pending     <= '0;
      state       <= IDLE;
    end else begin
      hit_flags   <= note_tick ? hit_now : '0;
      miss_flags  <= note_tick ? miss_now : '0;
      false_flags <= note_tick ? false_now : '0;
      if (note_tick) begin
        streak     <= streak_next;
        multiplier <= mult_for(streak_next);
      end
      pending <= pending_next;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pending != '0) state_next = ADD;
      ADD:  if (pending_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ADD) || (pending != '0);

  bcd_counter4 u_score (
    .clk   (CLOCK_50),
    .rst   (RESET_GAME),
    .inc   (inc),
    .count (score_bcd)
  );
endmodule

// File: doc/hit_judge_scorer.md
Name: hit_judge_scorer

Overview:
- Downstream consumer of the four per-track note shifters.
- Samples the bottom-row note bit of each lane on every lane-advance tick and compares it with debounced-edge key presses collected since the previous tick.
- Judges hits, misses and false presses, and maintains a streak and score multiplier.
- Accumulates a saturating 4-digit BCD score that drives the HEX display decoders directly.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the key synchronizer (minimum 2)
- STREAK_STEP, 8, streak length needed per multiplier increment
- MAX_MULT, 4, multiplier ceiling (at most 7)
- STREAK_MAX, 63, streak saturation value (6-bit)

Ports:
- CLOCK_50  in  1  system clock; all logic is synchronous to it
- RESET_GAME  in  1  asynchronous, active-high reset
- note_tick  in  1  one-cycle pulse in the CLOCK_50 domain; lanes advanced this cycle
- lane_note  in  4  bottom-row note bit per lane (bit3 = lane1 … bit0 = lane4); valid on note_tick
- KEY_N  in  4  raw, asynchronous, active-low buttons (bit3 = lane1)
- score_bcd  out  16  four BCD digits, [3:0] = ones
- streak  out  6  current consecutive clean-tick count
- multiplier  out  3  current multiplier, 1..MAX_MULT
- hit_flags  out  4  per-lane hit, registered, valid one cycle after note_tick
- miss_flags  out  4  per-lane miss (note present, no press), same timing as hit_flags
- false_flags  out  4  press with no note, same timing as hit_flags
- busy  out  1  score adder has pending points

Behaviour:
- Reset (asynchronous, RESET_GAME=1) clears:
  - score_bcd to 0000, streak to 0, all flags to 0, busy to 0
  - multiplier to 1
  - synchronizers to "released", press latches to 0, pending to 0, FSM to IDLE
- Key path:
  - KEY_N is inverted, then passed through SYNC_STAGES flops.
  - A rising edge of the synchronized press sets press_latch[i].
  - Key-to-latch latency is SYNC_STAGES+1 cycles.
  - Held keys do not re-trigger.
- Window: press_latch accumulates between ticks.
- On note_tick:
  - The window is closed using press_latch OR this cycle's edge; a same-cycle edge counts in the closing window.
  - press_latch is then cleared, so the next window starts empty.
- Judgement, registered at tick+1:
  - hit = note & press
  - miss = note & ~press
  - false = press & ~note
  - Flags are 1-cycle pulses, 0 otherwise.
- Streak:
  - If miss==0, false==0 and hit!=0: streak+1, saturating at STREAK_MAX.
  - If any miss or false: streak=0.
  - If no notes and no presses: streak unchanged.
- Multiplier = min(1 + streak/STREAK_STEP, MAX_MULT), computed from the updated streak and registered with it.
- Points per tick = popcount(hit) × multiplier computed with the pre-update streak (max 16).
  - Points are added to a 5-bit pending register, saturating at 31.
- Adder FSM:
  - IDLE: if pending>0, go to ADD.
  - ADD: each cycle, BCD-increment score_bcd by 1 and decrement pending; return to IDLE when pending reaches 0.
  - busy = (state==ADD) or pending>0.
  - A tick arriving during ADD adds its points to pending in the same cycle the FSM decrements (net = pending − 1 + points).
  - The score never drops points while pending < 31.
- BCD rules:
  - Each digit wraps 9→0 with a carry into the next digit.
  - At 9999 the score saturates: increments are discarded while pending still drains.
- Reset mid-ADD aborts immediately; pending is lost.
- note_tick asserted on consecutive cycles is legal; each cycle is a separate window.

Decomposition:
- Shared package gh_pkg holds:
  - lane count 4
  - BCD digit width 4
  - SCORE_MAX_BCD 16'h9999
  - the FSM state enum {IDLE, ADD}
- One sub-module, bcd_counter4: synchronous 4-digit BCD incrementer with inc enable, saturation at 9999, and asynchronous active-high clear.
- The synchronizer stays inline.

Test Plan:
- Reset: assert RESET_GAME for 3 cycles -> score_bcd=0000, streak=0, multiplier=1, all flags 0, busy=0.
- Single hit: press lane1 (KEY_N[3]=0) ≥SYNC_STAGES+1 cycles before a tick with lane_note=4'b1000 -> hit_flags=1000 at tick+1, streak=1, score 0001 after busy falls.
- Miss and false press: lane_note=0011 with only lane1 pressed -> miss_flags=0011, false_flags=1000, streak=0, score unchanged.
- Multiplier: 8 consecutive clean single-note hits -> multiplier=2 after the 8th tick; a 4-note hit on the 9th tick adds 8 points, for total score 0016.
- Back-to-back ticks during ADD: two 4-note hits at multiplier 4 one cycle apart -> pending peaks at 31; score rises by 31 (the second tick's 16 points saturate the pending register); busy stays high until the last increment; no other loss.
- Saturation and rollover: preload via 9995 hits, then a 4-note hit at mult 2 -> score reaches 9999 and holds; a digit carry check from 0099 to 0100 works.
